dffram_gen: RTL and testbench
=============================

DFFRAM_GEN -- requirements
Module: dffram_gen

Interface
REQ-001: Parameter DW, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002: Parameter DEPTH, default 4096: number of words; need not be a power of two.
REQ-003: Parameter INIT_ZERO, default 1: 1 = zero-scrub the whole array after reset; 0 = no scrub.
REQ-004: Derived constants: AW = max(1, clog2(DEPTH)) and BW = DW/8.
REQ-005: One clock; reset is synchronous and active-high.
REQ-006: clk_i  in  1  clock; all state updates on the rising edge.
REQ-007: rst_i  in  1  synchronous active-high reset.
REQ-008: req_valid_i  in  1  request valid.
REQ-009: req_ready_o  out  1  request accepted when high together with req_valid_i.
REQ-010: req_we_i  in  1  1 = write, 0 = read.
REQ-011: req_be_i  in  BW  byte-enable write mask; bit i covers bits [8i+7:8i].
REQ-012: req_addr_i  in  AW  word address.
REQ-013: req_wdata_i  in  DW  write data.
REQ-014: rsp_valid_o  out  1  response valid.
REQ-015: rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
REQ-016: rsp_rdata_o  out  DW  read data; 0 for writes and errors.
REQ-017: rsp_err_o  out  1  address-out-of-range error.
REQ-018: init_done_o  out  1  scrub complete; array ready for use.

Function
REQ-019: FSM states are INIT and RUN; reset enters INIT.
REQ-020: INIT with INIT_ZERO=1: writes all-zero to one address per cycle (0..DEPTH-1), then moves to RUN; scrub takes exactly DEPTH cycles.
REQ-021: INIT with INIT_ZERO=0: moves to RUN on the first cycle after reset.
REQ-022: init_done_o = 1 only in RUN; req_ready_o = 0 in INIT.
REQ-023: In RUN: req_ready_o = !rsp_valid_o || rsp_ready_i (single response holding register, combinational path from rsp_ready_i).
REQ-024: An accepted request produces rsp_valid_o = 1 on the next cycle (latency 1); back-to-back accepts give one response per cycle.
REQ-025: Read: rsp_rdata_o = mem[addr] sampled at acceptance; rsp_err_o = 0.
REQ-026: Write: only bytes with req_be_i set are updated, at acceptance; rsp_rdata_o = 0; rsp_err_o = 0. A write with be = 0 still returns a response.
REQ-027: Address >= DEPTH: no array access; response carries rsp_err_o = 1 and rsp_rdata_o = 0.
REQ-028: While rsp_valid_o = 1 and rsp_ready_i = 0, rsp_* remain stable and no new request is accepted.
REQ-029: A read at the address of the immediately preceding accepted write returns the written data (write is committed before the next acceptance).
REQ-030: A response consumed in the same cycle as a new acceptance is replaced by the new response with no bubble.

Reset
REQ-031: Reset values: rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, init_done_o = 0, req_ready_o = 0, scrub counter = 0, state = INIT.
REQ-032: rst_i asserted mid-scrub restarts the scrub at address 0.
REQ-033: rst_i asserted in RUN discards any pending response.
REQ-034: Array contents are not reset except by the scrub.

Structure
REQ-035: Package dffram_pkg SHALL hold the FSM state enum and the helper function that computes the byte-enable width.
REQ-036: Storage SHALL be a single sub-module, dffram_gen_array: synchronous, byte-masked, one port, parameters DW and DEPTH; the scrub and request paths are muxed into this one port.

Verification
REQ-037: DEPTH=16, INIT_ZERO=1: reset, then init_done_o rises exactly 16 cycles after rst_i falls, and reading all 16 addresses returns 0.
REQ-038: Write 0xDEADBEEF with be=0xF to addr 3, then write 0x000000AA with be=0x1 to addr 3, then read addr 3 -> 0xDEADBEAA, err=0.
REQ-039: DEPTH=12, read addr 13 -> rsp_err_o=1, rsp_rdata_o=0, and array contents unchanged.
REQ-040: Hold rsp_ready_i=0 for 5 cycles after a read -> rsp_* stable and req_ready_o=0 throughout; after ready rises, the next request is accepted in that same cycle.
REQ-041: Assert rst_i at scrub address 7 -> scrub restarts at 0 and init_done_o rises DEPTH cycles after rst_i falls.
REQ-042: Streaming 8 back-to-back reads with rsp_ready_i=1 -> 8 responses on consecutive cycles, in order, each 1 cycle after acceptance.

Source files
------------

// File: rtl/dffram_pkg.sv
// rtl/dffram_pkg.sv - shared types and width helpers for the dffram_gen word store
package dffram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

    // A single-word array still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dffram_gen_array.sv
// rtl/dffram_gen_array.sv - single-port synchronous byte-masked word array
module dffram_gen_array
    import dffram_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4096,
    localparam int AW    = addr_width(DEPTH),
    localparam int BW    = be_width(DW)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [BW-1:0] be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Read data only moves on an enabled read, so it holds while a response stalls.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BW; b++) begin
                    if (be_i[b]) begin
                        r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[addr_i];
            end
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/dffram_gen.sv
// rtl/dffram_gen.sv - flop-based word store with zero scrub and one-deep response register
module dffram_gen
    import dffram_pkg::*;
#(
    parameter  int DW        = 32,
    parameter  int DEPTH     = 4096,
    parameter  int INIT_ZERO = 1,
    localparam int AW        = addr_width(DEPTH),
    localparam int BW        = be_width(DW)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [BW-1:0] req_be_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          init_done_o
);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam bit            SCRUB     = (INIT_ZERO != 0);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_scrub_cnt;
    logic          w_scrub_last;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic          r_rsp_rd;
    logic          w_in_range;
    logic          w_accept;
    logic          w_mem_en;
    logic          w_mem_we;
    logic [BW-1:0] w_mem_be;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_mem_rdata;

    assign w_scrub_last = (r_scrub_cnt == LAST_ADDR);
    assign w_in_range   = ({1'b0, req_addr_i} < DEPTH_W);
    assign req_ready_o  = (r_state == ST_RUN) && (!r_rsp_valid || rsp_ready_i);
    assign w_accept     = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (!SCRUB || w_scrub_last) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scrub_cnt <= '0;
        end else if (r_state == ST_INIT && SCRUB) begin
            r_scrub_cnt <= w_scrub_last ? '0 : r_scrub_cnt + 1'b1;
        end
    end

    // The scrub owns the array port in INIT; requests own it in RUN.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (r_state == ST_INIT) begin
            w_mem_en   = SCRUB;
            w_mem_we   = 1'b1;
            w_mem_be   = '1;
            w_mem_addr = r_scrub_cnt;
        end else begin
            w_mem_en    = w_accept && w_in_range;
            w_mem_we    = req_we_i;
            w_mem_be    = req_be_i;
            w_mem_addr  = req_addr_i;
            w_mem_wdata = req_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_in_range;
            r_rsp_rd    <= w_in_range && !req_we_i;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= 1'b0;
        end
    end

    dffram_gen_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (w_mem_en),
        .we_i    (w_mem_we),
        .be_i    (w_mem_be),
        .addr_i  (w_mem_addr),
        .wdata_i (w_mem_wdata),
        .rdata_o (w_mem_rdata)
    );

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rd ? w_mem_rdata : '0;
    assign init_done_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_dffram_gen.sv
// tb/tb_dffram_gen.sv - directed bench driving a DEPTH=16 and a DEPTH=12 store in lockstep
module tb_dffram_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [3:0]  req_addr = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready = 1'b1;

    logic        req_ready16, rsp_valid16, rsp_err16, init_done16;
    logic [31:0] rsp_rdata16;
    logic        req_ready12, rsp_valid12, rsp_err12, init_done12;
    logic [31:0] rsp_rdata12;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dffram_gen #(.DW(32), .DEPTH(16), .INIT_ZERO(1)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready16),
        .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid16), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata16),
        .rsp_err_o(rsp_err16), .init_done_o(init_done16)
    );

    dffram_gen #(.DW(32), .DEPTH(12), .INIT_ZERO(1)) u_dut12 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready12),
        .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid12), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata12),
        .rsp_err_o(rsp_err12), .init_done_o(init_done12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with an idle cycle after it; returns the response seen by each DUT.
    task automatic xact(input logic we, input logic [3:0] be, input logic [3:0] addr,
                        input logic [31:0] wd,
                        output logic v16, output logic [31:0] d16, output logic e16,
                        output logic v12, output logic [31:0] d12, output logic e12);
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        v16 = rsp_valid16; d16 = rsp_rdata16; e16 = rsp_err16;
        v12 = rsp_valid12; d12 = rsp_rdata12; e12 = rsp_err12;
        tick();
    endtask

    task automatic wait_init(input string name, input int exp16, input int exp12);
        int n16 = -1;
        int n12 = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (init_done16 && n16 < 0) n16 = n;
            if (init_done12 && n12 < 0) n12 = n;
        end
        total++;
        if (n16 !== exp16) begin
            bad++;
            $display("FAIL %s_d16 init_done cycles got=%0d exp=%0d", name, n16, exp16);
        end
        total++;
        if (n12 !== exp12) begin
            bad++;
            $display("FAIL %s_d12 init_done cycles got=%0d exp=%0d", name, n12, exp12);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if ({rsp_valid16, rsp_err16, init_done16, req_ready16, rsp_rdata16} !== 36'h0) begin
            bad++;
            $display("FAIL reset_d16 got v=%b e=%b done=%b rdy=%b d=%h exp all 0",
                     rsp_valid16, rsp_err16, init_done16, req_ready16, rsp_rdata16);
        end
        total++;
        if ({rsp_valid12, init_done12, req_ready12} !== 3'b000) begin
            bad++;
            $display("FAIL reset_d12 got v=%b done=%b rdy=%b exp 000",
                     rsp_valid12, init_done12, req_ready12);
        end
        rst = 1'b0;
    endtask

    task automatic test_scrub();
        logic v16, e16, v12, e12;
        logic [31:0] d16, d12;
        wait_init("scrub", 16, 12);
        for (int a = 0; a < 16; a++) begin
            xact(1'b0, 4'h0, 4'(a), 32'h0, v16, d16, e16, v12, d12, e12);
            total++;
            if ({v16, e16, d16} !== {1'b1, 1'b0, 32'h0}) begin
                bad++;
                $display("FAIL scrub_rd16 a=%0d got v=%b e=%b d=%h exp v=1 e=0 d=0", a, v16, e16, d16);
            end
            total++;
            if ({v12, e12, d12} !== {1'b1, (a >= 12), 32'h0}) begin
                bad++;
                $display("FAIL scrub_rd12 a=%0d got v=%b e=%b d=%h exp v=1 e=%0d d=0",
                         a, v12, e12, d12, (a >= 12));
            end
        end
    endtask

    task automatic test_byte_write();
        logic v16, e16, v12, e12;
        logic [31:0] d16, d12;
        xact(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, v16, d16, e16, v12, d12, e12);
        total++;
        if ({v16, e16, d16} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL wr_full_rsp got v=%b e=%b d=%h exp v=1 e=0 d=0", v16, e16, d16);
        end
        xact(1'b1, 4'h1, 4'd3, 32'h000000AA, v16, d16, e16, v12, d12, e12);
        xact(1'b1, 4'h0, 4'd3, 32'h11111111, v16, d16, e16, v12, d12, e12);
        total++;
        if ({v16, e16, d16, v12} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL wr_be0_rsp got v=%b e=%b d=%h v12=%b exp v=1 e=0 d=0 v12=1",
                     v16, e16, d16, v12);
        end
        xact(1'b0, 4'h0, 4'd3, 32'h0, v16, d16, e16, v12, d12, e12);
        total++;
        if ({v16, e16, d16} !== {1'b1, 1'b0, 32'hDEADBEAA}) begin
            bad++;
            $display("FAIL byte_merge16 got v=%b e=%b d=%h exp v=1 e=0 d=deadbeaa", v16, e16, d16);
        end
        total++;
        if ({v12, e12, d12} !== {1'b1, 1'b0, 32'hDEADBEAA}) begin
            bad++;
            $display("FAIL byte_merge12 got v=%b e=%b d=%h exp v=1 e=0 d=deadbeaa", v12, e12, d12);
        end
    endtask

    task automatic test_out_of_range();
        logic v16, e16, v12, e12;
        logic [31:0] d16, d12;
        xact(1'b0, 4'h0, 4'd13, 32'h0, v16, d16, e16, v12, d12, e12);
        total++;
        if ({v12, e12, d12} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL oor_rd12 got v=%b e=%b d=%h exp v=1 e=1 d=0", v12, e12, d12);
        end
        xact(1'b1, 4'hF, 4'd13, 32'h12345678, v16, d16, e16, v12, d12, e12);
        total++;
        if ({v12, e12, d12, e16} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL oor_wr got v12=%b e12=%b d12=%h e16=%b exp 1 1 0 0", v12, e12, d12, e16);
        end
        xact(1'b0, 4'h0, 4'd13, 32'h0, v16, d16, e16, v12, d12, e12);
        total++;
        if ({e16, d16} !== {1'b0, 32'h12345678}) begin
            bad++;
            $display("FAIL inrange_rd16 got e=%b d=%h exp e=0 d=12345678", e16, d16);
        end
        xact(1'b0, 4'h0, 4'd5, 32'h0, v16, d16, e16, v12, d12, e12);
        total++;
        if ({e12, d12} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL oor_alias12 got e=%b d=%h exp e=0 d=0", e12, d12);
        end
        xact(1'b0, 4'h0, 4'd3, 32'h0, v16, d16, e16, v12, d12, e12);
        total++;
        if ({e12, d12} !== {1'b0, 32'hDEADBEAA}) begin
            bad++;
            $display("FAIL oor_keep12 got e=%b d=%h exp e=0 d=deadbeaa", e12, d12);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 4'd3; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        tick();
        req_addr = 4'd13;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({rsp_valid16, rsp_err16, rsp_rdata16, req_ready16} !== {1'b1, 1'b0, 32'hDEADBEAA, 1'b0}) begin
                bad++;
                $display("FAIL stall c=%0d got v=%b e=%b d=%h rdy=%b exp v=1 e=0 d=deadbeaa rdy=0",
                         c, rsp_valid16, rsp_err16, rsp_rdata16, req_ready16);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if ({req_ready16, req_ready12} !== 2'b11) begin
            bad++;
            $display("FAIL stall_release_rdy got %b%b exp 11", req_ready16, req_ready12);
        end
        tick();
        req_valid = 1'b0;
        total++;
        if ({rsp_valid16, rsp_err16, rsp_rdata16} !== {1'b1, 1'b0, 32'h12345678}) begin
            bad++;
            $display("FAIL stall_next16 got v=%b e=%b d=%h exp v=1 e=0 d=12345678",
                     rsp_valid16, rsp_err16, rsp_rdata16);
        end
        total++;
        if ({rsp_valid12, rsp_err12, rsp_rdata12} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL stall_next12 got v=%b e=%b d=%h exp v=1 e=1 d=0",
                     rsp_valid12, rsp_err12, rsp_rdata12);
        end
        tick();
        total++;
        if (rsp_valid16 !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain got v=%b exp 0", rsp_valid16);
        end
    endtask

    task automatic test_back_to_back();
        logic v16, e16, v12, e12;
        logic [31:0] d16, d12;
        for (int i = 0; i < 8; i++) begin
            xact(1'b1, 4'hF, 4'(i), 32'hC0DE0000 + 32'(i) * 32'h111, v16, d16, e16, v12, d12, e12);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(i);
            #1;
            total++;
            if (req_ready16 !== 1'b1) begin
                bad++;
                $display("FAIL stream_rdy i=%0d got %b exp 1", i, req_ready16);
            end
            tick();
            total++;
            if ({rsp_valid16, rsp_rdata16, rsp_rdata12} !==
                {1'b1, 32'hC0DE0000 + 32'(i) * 32'h111, 32'hC0DE0000 + 32'(i) * 32'h111}) begin
                bad++;
                $display("FAIL stream_rd i=%0d got v=%b d16=%h d12=%h exp v=1 d=%h",
                         i, rsp_valid16, rsp_rdata16, rsp_rdata12, 32'hC0DE0000 + 32'(i) * 32'h111);
            end
        end
        req_we = 1'b1; req_be = 4'hF; req_addr = 4'd9; req_wdata = 32'h5A5A1234;
        tick();
        total++;
        if ({rsp_valid16, rsp_rdata16} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL raw_wr got v=%b d=%h exp v=1 d=0", rsp_valid16, rsp_rdata16);
        end
        req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        total++;
        if ({rsp_valid16, rsp_rdata16, rsp_rdata12} !== {1'b1, 32'h5A5A1234, 32'h5A5A1234}) begin
            bad++;
            $display("FAIL raw_rd got v=%b d16=%h d12=%h exp v=1 d=5a5a1234",
                     rsp_valid16, rsp_rdata16, rsp_rdata12);
        end
        tick();
    endtask

    task automatic test_mid_scrub_reset();
        logic v16, e16, v12, e12;
        logic [31:0] d16, d12;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        total++;
        if ({init_done16, init_done12} !== 2'b00) begin
            bad++;
            $display("FAIL midscrub_done got %b%b exp 00", init_done16, init_done12);
        end
        rst = 1'b0;
        wait_init("midscrub", 16, 12);
        for (int a = 0; a < 16; a++) begin
            xact(1'b0, 4'h0, 4'(a), 32'h0, v16, d16, e16, v12, d12, e12);
            total++;
            if ({v16, e16, d16} !== {1'b1, 1'b0, 32'h0}) begin
                bad++;
                $display("FAIL rescrub_rd16 a=%0d got v=%b e=%b d=%h exp v=1 e=0 d=0", a, v16, e16, d16);
            end
        end
    endtask

    task automatic test_reset_discard();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        total++;
        if (rsp_valid16 !== 1'b1) begin
            bad++;
            $display("FAIL discard_pre got v=%b exp 1", rsp_valid16);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({rsp_valid16, rsp_rdata16, rsp_err16, req_ready16, init_done16} !== 36'h0) begin
            bad++;
            $display("FAIL discard got v=%b d=%h e=%b rdy=%b done=%b exp all 0",
                     rsp_valid16, rsp_rdata16, rsp_err16, req_ready16, init_done16);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scrub();
        test_byte_write();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_mid_scrub_reset();
        test_reset_discard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
